// File: rtl/dm_be_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dm_be_ctrl
//  Purpose  : Byte-enable data memory for the MIPS datapath. Accepts one
//             load or store per cycle over a req/ready handshake. Supports
//             byte, halfword and word accesses, with sign or zero extension
//             on loads. A clear engine fills the array with INIT_VAL after
//             reset and whenever clr_i is sampled in IDLE.
//  Options  : DM_TRACE_EN - when defined, prints a simulation trace line
//             for every error-free store at its write edge.
//  Revision : 1.0 - initial release
// ============================================================================
module dm_be_ctrl #(
    parameter int          ADDR_W   = 12,
    parameter logic [31:0] INIT_VAL = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        sext_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] pc_i,
    output logic        ready_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int         DEPTH   = 1 << ADDR_W;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   cnt_q;

    // Request decode
    logic                accept;
    logic                misalign;
    logic                st_ok;
    logic                ld_acc;
    logic [ADDR_W-1:0]   idx;

    // Array write port
    logic                mem_we;
    logic [3:0]          mem_be;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [31:0]         mem_wdata;
    logic [3:0]          st_be;
    logic [31:0]         st_data;

    // Load pipeline
    logic [31:0]         rd_word;
    logic                p1_load_q;
    logic                p1_err_q;
    logic [1:0]          p1_size_q;
    logic                p1_sext_q;
    logic [1:0]          p1_off_q;
    logic [7:0]          ld_byte;
    logic [15:0]         ld_half;
    logic [31:0]         rdata_d;
    logic                rvalid_q;
    logic                err_q;
    logic [31:0]         rdata_q;

    // Pins that only matter to the trace build or lie above the array span
    logic                unused_pins;
    assign unused_pins = ^{pc_i, addr_i[31:ADDR_W+2]};

    assign idx     = addr_i[ADDR_W+1:2];
    // clr_i wins over req_i in IDLE, so it must also drop ready immediately
    assign ready_o = (state_q == ST_IDLE) && !clr_i;
    assign accept  = req_i && ready_o;

    // Halfwords need even addresses, words need 4-byte alignment, size 11 is reserved
    always_comb begin
        misalign = 1'b0;
        case (size_i)
            SZ_BYTE: misalign = 1'b0;
            SZ_HALF: misalign = addr_i[0];
            SZ_WORD: misalign = (addr_i[1:0] != 2'b00);
            default: misalign = 1'b1;
        endcase
    end

    assign st_ok  = accept && we_i && !misalign;
    assign ld_acc = accept && !we_i;

    // Store lane enables and lane-replicated data; lanes are little-endian
    always_comb begin
        st_be   = 4'b0000;
        st_data = wdata_i;
        case (size_i)
            SZ_BYTE: begin
                st_be   = 4'b0001 << addr_i[1:0];
                st_data = {4{wdata_i[7:0]}};
            end
            SZ_HALF: begin
                st_be   = addr_i[1] ? 4'b1100 : 4'b0011;
                st_data = {2{wdata_i[15:0]}};
            end
            SZ_WORD: begin
                st_be   = 4'b1111;
                st_data = wdata_i;
            end
            default: begin
                st_be   = 4'b0000;
                st_data = wdata_i;
            end
        endcase
    end

    // Write port arbitration: the clear engine owns the array while in INIT
    always_comb begin
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_waddr = idx;
        mem_wdata = st_data;
        if (state_q == ST_INIT) begin
            mem_we    = 1'b1;
            mem_be    = 4'b1111;
            mem_waddr = cnt_q;
            mem_wdata = INIT_VAL;
        end else if (st_ok) begin
            mem_we    = 1'b1;
            mem_be    = st_be;
        end
    end

    // Control FSM: clear engine sweep and return to IDLE on the last word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (&cnt_q) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (clr_i) begin
                        state_q <= ST_INIT;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // One byte-wide array per lane so each lane has its own write enable
    for (genvar b = 0; b < 4; b++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];
        logic [7:0] lane_rd_q;

        // Lane write and synchronous lane read for accepted loads
        always_ff @(posedge clk) begin
            if (mem_we && mem_be[b]) begin
                lane_mem[mem_waddr] <= mem_wdata[8*b +: 8];
            end
            if (ld_acc) begin
                lane_rd_q <= lane_mem[idx];
            end
        end

        assign rd_word[8*b +: 8] = lane_rd_q;
    end

    // Stage 1: remember what the in-flight load needs for lane select and extension
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_load_q <= 1'b0;
            p1_err_q  <= 1'b0;
            p1_size_q <= SZ_BYTE;
            p1_sext_q <= 1'b0;
            p1_off_q  <= 2'b00;
        end else begin
            p1_load_q <= ld_acc;
            p1_err_q  <= accept && misalign;
            if (accept) begin
                p1_size_q <= size_i;
                p1_sext_q <= sext_i;
                p1_off_q  <= addr_i[1:0];
            end
        end
    end

    // Lane select on the word read from the array
    always_comb begin
        ld_byte = rd_word[7:0];
        case (p1_off_q)
            2'b00:   ld_byte = rd_word[7:0];
            2'b01:   ld_byte = rd_word[15:8];
            2'b10:   ld_byte = rd_word[23:16];
            default: ld_byte = rd_word[31:24];
        endcase
        ld_half = p1_off_q[1] ? rd_word[31:16] : rd_word[15:0];
    end

    // Extension to 32 bits; erroneous loads return zero
    always_comb begin
        rdata_d = rd_word;
        case (p1_size_q)
            SZ_BYTE: rdata_d = p1_sext_q ? {{24{ld_byte[7]}}, ld_byte} : {24'h0, ld_byte};
            SZ_HALF: rdata_d = p1_sext_q ? {{16{ld_half[15]}}, ld_half} : {16'h0, ld_half};
            default: rdata_d = rd_word;
        endcase
        if (p1_err_q) begin
            rdata_d = 32'h0;
        end
    end

    // Stage 2: registered response; rdata holds between loads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= 32'h0;
        end else begin
            rvalid_q <= p1_load_q;
            err_q    <= p1_err_q;
            if (p1_load_q) begin
                rdata_q <= rdata_d;
            end
        end
    end

    assign rvalid_o = rvalid_q;
    assign err_o    = err_q;
    assign rdata_o  = rdata_q;

`ifdef DM_TRACE_EN
    logic [31:0] trace_old;
    logic [31:0] trace_word;

    // Current word contents, merged with the store lanes for the printout
    always_comb begin
        trace_old  = {g_lane[3].lane_mem[idx], g_lane[2].lane_mem[idx],
                      g_lane[1].lane_mem[idx], g_lane[0].lane_mem[idx]};
        trace_word = trace_old;
        for (int i = 0; i < 4; i++) begin
            if (st_be[i]) begin
                trace_word[8*i +: 8] = st_data[8*i +: 8];
            end
        end
    end

    // One line per error-free store at its write edge; clear writes never qualify
    always_ff @(posedge clk) begin
        if (st_ok) begin
            $display("@%08h: *%08h <= %08h", pc_i, {addr_i[31:2], 2'b00}, trace_word);
        end
    end
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_dm_be_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dm_be_ctrl
//  Purpose  : Self-checking bench for dm_be_ctrl (ADDR_W=4). Expected
//             responses are queued when a request is driven and compared
//             when the DUT responds.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dm_be_ctrl;

    localparam int          AW = 4;
    localparam int          NW = 1 << AW;
    localparam logic [31:0] IV = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr_i;
    logic        req_i;
    logic        we_i;
    logic [1:0]  size_i;
    logic        sext_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] pc_i;
    logic        ready_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;

    dm_be_ctrl #(.ADDR_W(AW), .INIT_VAL(IV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (clr_i),
        .req_i    (req_i),
        .we_i     (we_i),
        .size_i   (size_i),
        .sext_i   (sext_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .pc_i     (pc_i),
        .ready_o  (ready_o),
        .rvalid_o (rvalid_o),
        .rdata_o  (rdata_o),
        .err_o    (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic        rv;
        logic        er;
        logic [31:0] rd;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] mdl [NW];
    int          vec_cnt = 0;
    int          miscmp  = 0;
    int          cyc     = 0;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miscmp++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor: compare at the due cycle, flag anything unexpected
    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            chk_val("rvalid", {31'h0, rvalid_o}, {31'h0, e.rv});
            chk_val("err", {31'h0, err_o}, {31'h0, e.er});
            if (e.rv) chk_val("rdata", rdata_o, e.rd);
        end else if (rvalid_o || err_o) begin
            chk_val("spurious_resp", {30'h0, rvalid_o, err_o}, 32'h0);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mdl_load(input logic [1:0] sz, input logic sx, input logic [31:0] a);
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        w = mdl[a[AW+1:2]];
        b = w[8*a[1:0] +: 8];
        h = w[16*a[1] +: 16];
        case (sz)
            2'd0:    return sx ? {{24{b[7]}}, b} : {24'h0, b};
            2'd1:    return sx ? {{16{h[15]}}, h} : {16'h0, h};
            default: return w;
        endcase
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!ready_o && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ready_o) chk_val("ready_timeout", {31'h0, ready_o}, 32'h1);
    endtask

    // Counts edges until ready rises; called right after the clear-starting edge
    task automatic clear_len(input string tag);
        int n = 0;
        while (!ready_o && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk_val(tag, n, NW);
        for (int i = 0; i < NW; i++) mdl[i] = IV;
    endtask

    // Drive one access for one cycle; queue its expected response
    task automatic issue(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd);
        logic bad;
        int   i;
        wait_ready();
        bad = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
        i   = int'(a[AW+1:2]);
        we_i = w; size_i = sz; sext_i = sx; addr_i = a; wdata_i = wd;
        pc_i = 32'h0040_0000 + $urandom_range(0, 255) * 4;
        req_i = 1'b1;
        if (w) begin
            if (bad) sbq.push_back('{cyc + 2, 1'b0, 1'b1, 32'h0});
            else begin
                case (sz)
                    2'd0:    mdl[i][8*a[1:0] +: 8] = wd[7:0];
                    2'd1:    mdl[i][16*a[1] +: 16] = wd[15:0];
                    default: mdl[i] = wd;
                endcase
            end
        end else begin
            sbq.push_back('{cyc + 2, 1'b1, bad, bad ? 32'h0 : exp_rd});
        end
        @(posedge clk); #1;
        req_i = 1'b0;
    endtask

    task automatic ld(input logic [1:0] sz, input logic sx, input logic [31:0] a, input logic [31:0] e);
        issue(1'b0, sz, sx, a, 32'h0, e);
    endtask

    task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        issue(1'b1, sz, 1'b0, a, d, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; clr_i = 1'b0; req_i = 1'b0; we_i = 1'b0; size_i = 2'd0;
        sext_i = 1'b0; addr_i = 32'h0; wdata_i = 32'h0; pc_i = 32'h0;
        for (int i = 0; i < NW; i++) mdl[i] = IV;
        repeat (2) @(posedge clk);
        #1;
        chk_val("rst_ready", {31'h0, ready_o}, 32'h0);
        chk_val("rst_rvalid", {31'h0, rvalid_o}, 32'h0);
        chk_val("rst_rdata", rdata_o, 32'h0);
        chk_val("rst_err", {31'h0, err_o}, 32'h0);

        // Clear after reset release, then sweep all words back-to-back
        rst_n = 1'b1;
        clear_len("init_len");
        for (int i = 0; i < NW; i++) ld(2'd2, 1'b0, i * 4, IV);

        // Byte and halfword lane selection
        st(2'd2, 32'h8, 32'h1122_3344);
        ld(2'd0, 1'b1, 32'h9, 32'h0000_0033);
        ld(2'd0, 1'b0, 32'hB, 32'h0000_0011);
        ld(2'd1, 1'b1, 32'hA, 32'h0000_1122);

        // Byte store merge and sign extension
        st(2'd2, 32'h4, 32'h0);
        st(2'd0, 32'h6, 32'h0000_0080);
        ld(2'd0, 1'b1, 32'h6, 32'hFFFF_FF80);
        ld(2'd2, 1'b0, 32'h4, 32'h0080_0000);
        ld(2'd1, 1'b1, 32'h6, 32'h0000_0080);

        // Misaligned and reserved-size accesses
        ld(2'd1, 1'b0, 32'h1, 32'h0);
        st(2'd2, 32'h2, 32'hCAFE_F00D);
        ld(2'd3, 1'b0, 32'h0, 32'h0);
        ld(2'd2, 1'b0, 32'h0, IV);
        ld(2'd2, 1'b0, 32'h8, 32'h1122_3344);

        // Random aligned traffic against the model
        for (int k = 0; k < 40; k++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            sz = 2'($urandom_range(0, 2));
            a  = $urandom_range(0, NW * 4 - 1);
            if (sz == 2'd1) a[0] = 1'b0;
            if (sz == 2'd2) a[1:0] = 2'b00;
            if ($urandom_range(0, 1) == 1) st(sz, a, $urandom);
            else begin
                logic sx;
                sx = 1'($urandom_range(0, 1));
                ld(sz, sx, a, mdl_load(sz, sx, a));
            end
        end

        // clr pulse with a competing req: ready drops at once, req ignored
        st(2'd2, 32'h0, 32'hDEAD_BEEF);
        ld(2'd2, 1'b0, 32'h0, 32'hDEAD_BEEF);
        wait_ready();
        clr_i = 1'b1; req_i = 1'b1; we_i = 1'b0; size_i = 2'd2; addr_i = 32'h0;
        #1;
        chk_val("clr_ready_drop", {31'h0, ready_o}, 32'h0);
        @(posedge clk); #1;
        clr_i = 1'b0; req_i = 1'b0;
        clear_len("clr_len");
        ld(2'd2, 1'b0, 32'h0, IV);

        // clr in the same cycle as an earlier load's rvalid
        st(2'd2, 32'h10, 32'h0BAD_F00D);
        ld(2'd2, 1'b0, 32'h10, 32'h0BAD_F00D);
        @(posedge clk); #1;
        clr_i = 1'b1;
        @(posedge clk); #1;
        clr_i = 1'b0;
        clear_len("clr_rv_len");

        // Reset at clear count 5 restarts the full sweep
        wait_ready();
        clr_i = 1'b1;
        @(posedge clk); #1;
        clr_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_len("rst_mid_init_len");

        // Reset while a load is outstanding suppresses its rvalid
        st(2'd2, 32'h14, 32'h1357_9BDF);
        issue(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 32'h0);
        sbq.delete();
        rst_n = 1'b0;
        #1;
        chk_val("rst_load_rvalid", {31'h0, rvalid_o}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_len("rst_load_len");
        ld(2'd2, 1'b0, 32'h14, IV);
        ld(2'd0, 1'b0, 32'h17, IV);

        repeat (4) @(posedge clk);
        #1;
        chk_val("sb_drain", sbq.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule
`default_nettype wire
